// File: rtl/data_memory_pipe_pkg.sv
// Shared types for the MEM-stage data memory: access-size encoding, FSM states, store lane bundle.
// Pure declarations, no logic or latency.
// No flow control of its own; used by data_memory_pipe and dm_lane_align.
package dm_pkg;

  // Access size / extension as encoded on req_ctrl (RV32 funct3 of loads/stores)
  typedef enum logic [2:0] {
    DM_B  = 3'b000,
    DM_H  = 3'b001,
    DM_W  = 3'b010,
    DM_BU = 3'b100,
    DM_HU = 3'b101
  } dm_ctrl_e;

  // Controller states: clearing sweep, then serving requests forever
  typedef enum logic {
    DM_INIT = 1'b0,
    DM_RUN  = 1'b1
  } dm_state_e;

  // Lane-aligned store: byte enables plus data replicated/shifted onto the lanes
  typedef struct packed {
    logic [3:0]  be;
    logic [31:0] wdata;
  } dm_store_t;

endpackage

// File: rtl/dm_lane_align.sv
// Lane alignment for byte-addressable access: store byte-enables/shift, load extract/extend, fault flags.
// Purely combinational, zero latency.
// No flow control; the caller decides whether the result is used.
module dm_lane_align
  import dm_pkg::*;
(
  input  logic        we_i,
  input  logic [2:0]  ctrl_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output dm_store_t   store_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o,
  output logic        illegal_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Pick the addressed byte and halfword out of the stored word
  always_comb begin
    byte_v = rword_i[7:0];
    case (addr_lo_i)
      2'd0: byte_v = rword_i[7:0];
      2'd1: byte_v = rword_i[15:8];
      2'd2: byte_v = rword_i[23:16];
      2'd3: byte_v = rword_i[31:24];
      default: byte_v = rword_i[7:0];
    endcase
    half_v = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
  end

  // Decode size: enables, replicated store data, extended load data, alignment/legality
  always_comb begin
    store_o    = '0;
    rdata_o    = '0;
    misalign_o = 1'b0;
    illegal_o  = 1'b0;
    case (ctrl_i)
      DM_B, DM_BU: begin
        store_o.be    = 4'b0001 << addr_lo_i;
        store_o.wdata = {4{wdata_i[7:0]}};
        rdata_o       = (ctrl_i == DM_BU) ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
      end
      DM_H, DM_HU: begin
        misalign_o    = addr_lo_i[0];
        store_o.be    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        store_o.wdata = {2{wdata_i[15:0]}};
        rdata_o       = (ctrl_i == DM_HU) ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
      end
      DM_W: begin
        misalign_o    = (addr_lo_i != 2'b00);
        store_o.be    = 4'b1111;
        store_o.wdata = wdata_i;
        rdata_o       = rword_i;
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
    // Unsigned variants only make sense for loads
    if (we_i && ((ctrl_i == DM_BU) || (ctrl_i == DM_HU))) begin
      illegal_o = 1'b1;
    end
  end

endmodule

// File: rtl/data_memory_pipe.sv
// Byte-addressable RV32 data memory with optional post-reset clearing sweep.
// Latency: response registered one cycle after accept; one request per cycle.
// Backpressure: req_ready low only during reset/sweep; responses cannot be stalled.
module data_memory_pipe
  import dm_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int INIT_ZERO   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_ctrl,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        init_done
);

  localparam int IDXW = $clog2(DEPTH_WORDS);

  logic [31:0] mem_q [DEPTH_WORDS];

  dm_state_e   state_q, state_d;
  logic [IDXW:0] ptr_q, ptr_d;
  logic        sweep_we;

  logic        accept;
  logic [IDXW-1:0] word_idx;
  logic [31:0] rword;
  logic        out_of_range;
  logic        misalign;
  logic        illegal;
  logic        acc_err;
  logic        store_we;
  dm_store_t   store;
  logic [31:0] load_data;

  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  // Anything above the last byte of the array is out of range
  assign out_of_range = (req_addr[31:IDXW+2] != '0);
  assign word_idx     = req_addr[IDXW+1:2];
  assign rword        = mem_q[word_idx];

  dm_lane_align u_lane_align (
    .we_i       (req_we),
    .ctrl_i     (req_ctrl),
    .addr_lo_i  (req_addr[1:0]),
    .wdata_i    (req_wdata),
    .rword_i    (rword),
    .store_o    (store),
    .rdata_o    (load_data),
    .misalign_o (misalign),
    .illegal_o  (illegal)
  );

  assign acc_err  = misalign | illegal | out_of_range;
  assign accept   = req_valid & req_ready;
  assign store_we = accept & req_we & ~acc_err;

  // Next-state: sweep one word per cycle until the wide pointer wraps, then serve requests
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sweep_we  = 1'b0;
    req_ready = 1'b0;
    init_done = 1'b0;
    case (state_q)
      DM_INIT: begin
        sweep_we = rst_n;
        ptr_d    = ptr_q + 1'b1;
        if (ptr_d[IDXW]) begin
          state_d = DM_RUN;
        end
      end
      DM_RUN: begin
        req_ready = rst_n;
        init_done = rst_n;
      end
      default: begin
        state_d = DM_INIT;
      end
    endcase
  end

  // State and sweep pointer, synchronously reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
      if (INIT_ZERO != 0) begin
        state_q <= DM_INIT;
      end else begin
        state_q <= DM_RUN;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Storage array: sweep clears, accepted legal stores write enabled bytes; reset leaves it alone
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem_q[ptr_q[IDXW-1:0]] <= '0;
    end else if (store_we) begin
      for (int b = 0; b < 4; b++) begin
        if (store.be[b]) begin
          mem_q[word_idx][8*b +: 8] <= store.wdata[8*b +: 8];
        end
      end
    end
  end

  // Response registers: pulse valid per accept, hold data/err across idle cycles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= accept;
      if (accept) begin
        rsp_rdata_q <= (req_we || acc_err) ? 32'h0 : load_data;
        rsp_err_q   <= acc_err;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_memory_pipe.sv
// Self-checking bench for data_memory_pipe: sweep, loads/stores, back-to-back, errors, reset, no-sweep variant.
module tb_data_memory_pipe;
  import dm_pkg::*;

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  ctrl;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic        err;
  } vec_t;

  logic        clk;
  logic        rst_n, req_valid, req_ready, req_we, rsp_valid, rsp_err, init_done;
  logic [2:0]  req_ctrl;
  logic [31:0] req_addr, req_wdata, rsp_rdata;

  logic        z_rst_n, z_req_valid, z_req_ready, z_req_we, z_rsp_valid, z_rsp_err, z_init_done;
  logic [2:0]  z_req_ctrl;
  logic [31:0] z_req_addr, z_req_wdata, z_rsp_rdata;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t exp_q[$];

  data_memory_pipe #(.DEPTH_WORDS(16), .INIT_ZERO(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_ctrl(req_ctrl), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .init_done(init_done)
  );

  data_memory_pipe #(.DEPTH_WORDS(16), .INIT_ZERO(0)) dut_z (
    .clk(clk), .rst_n(z_rst_n), .req_valid(z_req_valid), .req_ready(z_req_ready),
    .req_we(z_req_we), .req_ctrl(z_req_ctrl), .req_addr(z_req_addr), .req_wdata(z_req_wdata),
    .rsp_valid(z_rsp_valid), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err), .init_done(z_init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic we, input logic [2:0] ctrl, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rd, input logic err);
    vec_t v;
    v.we = we; v.ctrl = ctrl; v.addr = addr; v.wdata = wdata; v.rd = rd; v.err = err;
    return v;
  endfunction

  // Called at a negedge: presents one request, records its expected response,
  // returns at the following negedge with the response visible and req_valid low.
  task automatic req_a(input vec_t v);
    req_valid = 1'b1;
    req_we    = v.we;
    req_ctrl  = v.ctrl;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    exp_q.push_back('{rd: v.rd, err: v.err});
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    int early;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_ctrl = 3'b010;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0 || init_done !== 1'b0)
      $display("FAIL reset_outputs: ready=%b valid=%b rdata=%h err=%b done=%b, want all 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err, init_done);
    else n_pass++;
    rst_n = 1'b1;
    early = 0;
    for (int i = 0; i < 16; i++) begin
      if (req_ready !== 1'b0 || init_done !== 1'b0) early++;
      @(negedge clk);
    end
    n_checks++;
    if (early != 0) $display("FAIL sweep_ready_low: %0d of 16 sweep cycles had ready/done high, want 0", early);
    else n_pass++;
    n_checks++;
    if (req_ready !== 1'b1 || init_done !== 1'b1)
      $display("FAIL sweep_done: ready=%b done=%b after 16 cycles, want 1 1", req_ready, init_done);
    else n_pass++;
  endtask

  task automatic test_loads();
    vec_t v[$];
    exp_t e;
    v.push_back(mk(1'b0, DM_W,  32'h3C, 32'h0, 32'h0000_0000, 1'b0));
    v.push_back(mk(1'b1, DM_W,  32'h10, 32'h8081_7F80, 32'h0, 1'b0));
    v.push_back(mk(1'b0, DM_B,  32'h10, 32'h0, 32'hFFFF_FF80, 1'b0));
    v.push_back(mk(1'b0, DM_BU, 32'h10, 32'h0, 32'h0000_0080, 1'b0));
    v.push_back(mk(1'b0, DM_H,  32'h10, 32'h0, 32'h0000_7F80, 1'b0));
    v.push_back(mk(1'b0, DM_HU, 32'h10, 32'h0, 32'h0000_7F80, 1'b0));
    v.push_back(mk(1'b0, DM_B,  32'h13, 32'h0, 32'hFFFF_FF80, 1'b0));
    v.push_back(mk(1'b0, DM_HU, 32'h12, 32'h0, 32'h0000_8081, 1'b0));
    v.push_back(mk(1'b0, DM_H,  32'h12, 32'h0, 32'hFFFF_8081, 1'b0));
    v.push_back(mk(1'b0, DM_BU, 32'h11, 32'h0, 32'h0000_007F, 1'b0));
    v.push_back(mk(1'b0, DM_W,  32'h10, 32'h0, 32'h8081_7F80, 1'b0));
    for (int i = 0; i < v.size(); i++) begin
      req_a(v[i]);
      e = exp_q.pop_front();
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== e.rd || rsp_err !== e.err)
        $display("FAIL loads[%0d]: valid=%b rdata=%h err=%b, want valid=1 rdata=%h err=%b",
                 i, rsp_valid, rsp_rdata, rsp_err, e.rd, e.err);
      else n_pass++;
    end
    // Idle cycle: no pulse, data held from the last response
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h8081_7F80 || rsp_err !== 1'b0)
      $display("FAIL idle_hold: valid=%b rdata=%h err=%b, want 0 80817f80 0", rsp_valid, rsp_rdata, rsp_err);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    vec_t v[$];
    exp_t e;
    v.push_back(mk(1'b1, DM_B,  32'h21, 32'h0000_00AA, 32'h0, 1'b0));
    v.push_back(mk(1'b0, DM_W,  32'h20, 32'h0, 32'h0000_AA00, 1'b0));
    v.push_back(mk(1'b0, DM_B,  32'h21, 32'h0, 32'hFFFF_FFAA, 1'b0));
    v.push_back(mk(1'b0, DM_H,  32'h20, 32'h0, 32'hFFFF_AA00, 1'b0));
    for (int i = 0; i < v.size(); i++) begin
      req_a(v[i]);
      e = exp_q.pop_front();
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== e.rd || rsp_err !== e.err)
        $display("FAIL b2b[%0d]: valid=%b rdata=%h err=%b, want valid=1 rdata=%h err=%b",
                 i, rsp_valid, rsp_rdata, rsp_err, e.rd, e.err);
      else n_pass++;
    end
  endtask

  task automatic test_errors();
    vec_t v[$];
    exp_t e;
    v.push_back(mk(1'b0, DM_H,   32'h05,  32'h0, 32'h0, 1'b1));
    v.push_back(mk(1'b1, DM_W,   32'h22,  32'hDEAD_BEEF, 32'h0, 1'b1));
    v.push_back(mk(1'b0, DM_W,   32'h20,  32'h0, 32'h0000_AA00, 1'b0));
    v.push_back(mk(1'b0, DM_W,   32'h40,  32'h0, 32'h0, 1'b1));
    v.push_back(mk(1'b0, 3'b111, 32'h00,  32'h0, 32'h0, 1'b1));
    v.push_back(mk(1'b1, DM_BU,  32'h20,  32'h0000_00FF, 32'h0, 1'b1));
    v.push_back(mk(1'b1, 3'b011, 32'h20,  32'h1111_1111, 32'h0, 1'b1));
    v.push_back(mk(1'b1, DM_H,   32'h41,  32'h0000_5555, 32'h0, 1'b1));
    v.push_back(mk(1'b0, DM_W,   32'h20,  32'h0, 32'h0000_AA00, 1'b0));
    v.push_back(mk(1'b1, DM_H,   32'h22,  32'h0000_1234, 32'h0, 1'b0));
    v.push_back(mk(1'b0, DM_W,   32'h20,  32'h0, 32'h1234_AA00, 1'b0));
    v.push_back(mk(1'b0, DM_HU,  32'h23,  32'h0, 32'h0, 1'b1));
    v.push_back(mk(1'b0, DM_W,   32'h3FC, 32'h0, 32'h0, 1'b1));
    v.push_back(mk(1'b0, DM_B,   32'h3F,  32'h0, 32'h0, 1'b0));
    for (int i = 0; i < v.size(); i++) begin
      req_a(v[i]);
      e = exp_q.pop_front();
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== e.rd || rsp_err !== e.err)
        $display("FAIL errors[%0d]: valid=%b rdata=%h err=%b, want valid=1 rdata=%h err=%b",
                 i, rsp_valid, rsp_rdata, rsp_err, e.rd, e.err);
      else n_pass++;
    end
  endtask

  task automatic test_reset_midflight();
    vec_t v[$];
    exp_t e;
    int   waited;
    // Load accepted, then reset lands on the edge that would follow it
    req_valid = 1'b1; req_we = 1'b0; req_ctrl = DM_W; req_addr = 32'h20;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || init_done !== 1'b0 || req_ready !== 1'b0)
      $display("FAIL midflight_drop: valid=%b rdata=%h done=%b ready=%b, want 0 0 0 0",
               rsp_valid, rsp_rdata, init_done, req_ready);
    else n_pass++;
    rst_n  = 1'b1;
    waited = 0;
    while (init_done !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (waited != 16) $display("FAIL resweep_len: init_done after %0d cycles, want 16", waited);
    else n_pass++;
    v.push_back(mk(1'b0, DM_W, 32'h20, 32'h0, 32'h0, 1'b0));
    v.push_back(mk(1'b0, DM_W, 32'h10, 32'h0, 32'h0, 1'b0));
    for (int i = 0; i < v.size(); i++) begin
      req_a(v[i]);
      e = exp_q.pop_front();
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== e.rd || rsp_err !== e.err)
        $display("FAIL after_reset[%0d]: valid=%b rdata=%h err=%b, want valid=1 rdata=%h err=%b",
                 i, rsp_valid, rsp_rdata, rsp_err, e.rd, e.err);
      else n_pass++;
    end
  endtask

  task automatic test_no_init();
    vec_t v[$];
    exp_t e;
    z_rst_n = 1'b0; z_req_valid = 1'b0; z_req_we = 1'b0; z_req_ctrl = DM_W;
    z_req_addr = '0; z_req_wdata = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (z_req_ready !== 1'b0 || z_rsp_valid !== 1'b0 || z_init_done !== 1'b0)
      $display("FAIL noinit_reset: ready=%b valid=%b done=%b, want 0 0 0", z_req_ready, z_rsp_valid, z_init_done);
    else n_pass++;
    z_rst_n = 1'b1;
    #1;
    n_checks++;
    if (z_req_ready !== 1'b1 || z_init_done !== 1'b1)
      $display("FAIL noinit_ready: ready=%b done=%b on first cycle, want 1 1", z_req_ready, z_init_done);
    else n_pass++;
    v.push_back(mk(1'b1, DM_W,  32'h08, 32'hCAFE_F00D, 32'h0, 1'b0));
    v.push_back(mk(1'b0, DM_W,  32'h08, 32'h0, 32'hCAFE_F00D, 1'b0));
    v.push_back(mk(1'b1, DM_B,  32'h0A, 32'h0000_0091, 32'h0, 1'b0));
    v.push_back(mk(1'b0, DM_HU, 32'h0A, 32'h0, 32'h0000_CA91, 1'b0));
    for (int i = 0; i < v.size(); i++) begin
      z_req_valid = 1'b1; z_req_we = v[i].we; z_req_ctrl = v[i].ctrl;
      z_req_addr  = v[i].addr; z_req_wdata = v[i].wdata;
      exp_q.push_back('{rd: v[i].rd, err: v[i].err});
      @(negedge clk);
      z_req_valid = 1'b0;
      e = exp_q.pop_front();
      n_checks++;
      if (z_rsp_valid !== 1'b1 || z_rsp_rdata !== e.rd || z_rsp_err !== e.err)
        $display("FAIL noinit[%0d]: valid=%b rdata=%h err=%b, want valid=1 rdata=%h err=%b",
                 i, z_rsp_valid, z_rsp_rdata, z_rsp_err, e.rd, e.err);
      else n_pass++;
    end
  endtask

  initial begin
    z_rst_n = 1'b0; z_req_valid = 1'b0; z_req_we = 1'b0; z_req_ctrl = DM_W;
    z_req_addr = '0; z_req_wdata = '0;
    @(negedge clk);
    test_reset();
    test_loads();
    test_back_to_back();
    test_errors();
    test_reset_midflight();
    test_no_init();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
